// File: rtl/hazard_ctrl_if.sv
// Signal bundle between the pipeline datapath and the hazard controller:
// compare/control inputs from the datapath, stage enables and forwarding selects back.
interface hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             zero1, zero2, zero3, zero4;
    logic             ID_EX_rd_nz, EX_MEM_rd_nz;
    logic             ID_EX_regwrite, ID_EX_memread, EX_MEM_regwrite;
    logic             use_rs1, use_rs2;
    logic             branch_taken, ex_busy;
    logic             pc_write, IF_ID_write, ID_EX_write;
    logic             IF_ID_flush, ID_EX_bubble;
    logic [1:0]       fwd_a, fwd_b;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    modport slave (
        input  zero1, zero2, zero3, zero4, ID_EX_rd_nz, EX_MEM_rd_nz,
               ID_EX_regwrite, ID_EX_memread, EX_MEM_regwrite,
               use_rs1, use_rs2, branch_taken, ex_busy,
        output pc_write, IF_ID_write, ID_EX_write, IF_ID_flush, ID_EX_bubble,
               fwd_a, fwd_b, stall_cnt, flush_cnt
    );

    modport master (
        output zero1, zero2, zero3, zero4, ID_EX_rd_nz, EX_MEM_rd_nz,
               ID_EX_regwrite, ID_EX_memread, EX_MEM_regwrite,
               use_rs1, use_rs2, branch_taken, ex_busy,
        input  pc_write, IF_ID_write, ID_EX_write, IF_ID_flush, ID_EX_bubble,
               fwd_a, fwd_b, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, branch flush, multi-cycle EX freeze,
// registered operand forwarding selects and saturating stall/flush event counters.
module hazard_ctrl #(
    parameter int FLUSH_LEN = 1,
    parameter int CNT_W     = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    hazard_ctrl_if.slave bus
);
    typedef enum logic [1:0] {RUN, FLUSH, FREEZE} state_t;

    localparam logic [2:0] RELOAD = 3'(FLUSH_LEN - 1);

    state_t           state_q, state_d;
    logic [2:0]       fcnt_q, fcnt_d;
    logic [1:0]       fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

    logic m1, m2, lu, flushing;
    logic pc_wr, ifid_wr, idex_wr, ifid_flush, idex_bubble, lu_stall;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        if (en && (v != '1)) return v + CNT_W'(1);
        return v;
    endfunction

    function automatic logic [1:0] fwd_sel(input logic hit_ex, input logic hit_mem);
        if (hit_ex)  return 2'b01;
        if (hit_mem) return 2'b10;
        return 2'b00;
    endfunction

    assign m1 = bus.ID_EX_regwrite & bus.ID_EX_rd_nz;
    assign m2 = bus.EX_MEM_regwrite & bus.EX_MEM_rd_nz;
    assign lu = bus.ID_EX_memread & m1 &
                ((bus.zero1 & bus.use_rs1) | (bus.zero2 & bus.use_rs2));

    // A freeze that interrupted a flush resumes it once EX completes.
    assign flushing = (state_q == FLUSH) || ((state_q == FREEZE) && (fcnt_q != 3'd0));

    always_comb begin
        state_d     = state_q;
        fcnt_d      = fcnt_q;
        pc_wr       = 1'b1;
        ifid_wr     = 1'b1;
        idex_wr     = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        lu_stall    = 1'b0;
        if (bus.ex_busy) begin
            pc_wr   = 1'b0;
            ifid_wr = 1'b0;
            idex_wr = 1'b0;
            state_d = FREEZE;
        end else if (bus.branch_taken) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            fcnt_d      = RELOAD;
            state_d     = (RELOAD != 3'd0) ? FLUSH : RUN;
        end else if (flushing) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            fcnt_d      = fcnt_q - 3'd1;
            state_d     = (fcnt_q == 3'd1) ? RUN : FLUSH;
        end else begin
            state_d = RUN;
            if (lu) begin
                pc_wr       = 1'b0;
                ifid_wr     = 1'b0;
                idex_bubble = 1'b1;
                lu_stall    = 1'b1;
            end
        end
        // Enables must look like a free-running pipeline while held in reset.
        if (!rst_n) begin
            pc_wr       = 1'b1;
            ifid_wr     = 1'b1;
            idex_wr     = 1'b1;
            ifid_flush  = 1'b0;
            idex_bubble = 1'b0;
            lu_stall    = 1'b0;
        end
    end

    always_comb begin
        fwd_a_d = fwd_a_q;
        fwd_b_d = fwd_b_q;
        if (idex_wr) begin
            fwd_a_d = idex_bubble ? 2'b00 :
                      fwd_sel(m1 & bus.zero1 & bus.use_rs1, m2 & bus.zero3 & bus.use_rs1);
            fwd_b_d = idex_bubble ? 2'b00 :
                      fwd_sel(m1 & bus.zero2 & bus.use_rs2, m2 & bus.zero4 & bus.use_rs2);
        end
        stall_cnt_d = sat_inc(stall_cnt_q, lu_stall | bus.ex_busy);
        flush_cnt_d = sat_inc(flush_cnt_q, ifid_flush);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RUN;
            fcnt_q      <= 3'd0;
            fwd_a_q     <= 2'b00;
            fwd_b_q     <= 2'b00;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            fcnt_q      <= fcnt_d;
            fwd_a_q     <= fwd_a_d;
            fwd_b_q     <= fwd_b_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign bus.pc_write     = pc_wr;
    assign bus.IF_ID_write  = ifid_wr;
    assign bus.ID_EX_write  = idex_wr;
    assign bus.IF_ID_flush  = ifid_flush;
    assign bus.ID_EX_bubble = idex_bubble;
    assign bus.fwd_a        = fwd_a_q;
    assign bus.fwd_b        = fwd_b_q;
    assign bus.stall_cnt    = stall_cnt_q;
    assign bus.flush_cnt    = flush_cnt_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: two instances (FLUSH_LEN=2 with 3-bit counters,
// FLUSH_LEN=3 with 16-bit counters) share one set of stimulus inputs.
module tb_hazard_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    logic zero1, zero2, zero3, zero4, ID_EX_rd_nz, EX_MEM_rd_nz;
    logic ID_EX_regwrite, ID_EX_memread, EX_MEM_regwrite;
    logic use_rs1, use_rs2, branch_taken, ex_busy;

    always #5 clk = ~clk;

    hazard_ctrl_if #(.CNT_W(3))  b2 ();
    hazard_ctrl_if #(.CNT_W(16)) b3 ();

    assign {b2.zero1, b2.zero2, b2.zero3, b2.zero4} = {zero1, zero2, zero3, zero4};
    assign {b3.zero1, b3.zero2, b3.zero3, b3.zero4} = {zero1, zero2, zero3, zero4};
    assign {b2.ID_EX_rd_nz, b2.EX_MEM_rd_nz, b2.ID_EX_regwrite, b2.ID_EX_memread, b2.EX_MEM_regwrite} =
           {ID_EX_rd_nz, EX_MEM_rd_nz, ID_EX_regwrite, ID_EX_memread, EX_MEM_regwrite};
    assign {b3.ID_EX_rd_nz, b3.EX_MEM_rd_nz, b3.ID_EX_regwrite, b3.ID_EX_memread, b3.EX_MEM_regwrite} =
           {ID_EX_rd_nz, EX_MEM_rd_nz, ID_EX_regwrite, ID_EX_memread, EX_MEM_regwrite};
    assign {b2.use_rs1, b2.use_rs2, b2.branch_taken, b2.ex_busy} = {use_rs1, use_rs2, branch_taken, ex_busy};
    assign {b3.use_rs1, b3.use_rs2, b3.branch_taken, b3.ex_busy} = {use_rs1, use_rs2, branch_taken, ex_busy};

    hazard_ctrl #(.FLUSH_LEN(2), .CNT_W(3))  dut2 (.clk(clk), .rst_n(rst_n), .bus(b2));
    hazard_ctrl #(.FLUSH_LEN(3), .CNT_W(16)) dut3 (.clk(clk), .rst_n(rst_n), .bus(b3));

    task automatic clear_inputs;
        {zero1, zero2, zero3, zero4} = 4'b0;
        {ID_EX_rd_nz, EX_MEM_rd_nz, ID_EX_regwrite, ID_EX_memread, EX_MEM_regwrite} = 5'b0;
        {use_rs1, use_rs2, branch_taken, ex_busy} = 4'b0;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        clear_inputs();
        tick();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        clear_inputs();
        ex_busy = 1'b1; branch_taken = 1'b1;
        ID_EX_memread = 1'b1; ID_EX_regwrite = 1'b1; ID_EX_rd_nz = 1'b1; zero1 = 1'b1; use_rs1 = 1'b1;
        tick();
        total++;
        if ({b2.pc_write, b2.IF_ID_write, b2.ID_EX_write, b2.IF_ID_flush, b2.ID_EX_bubble} !== 5'b11100) begin
            bad++; $display("FAIL rst_enables: got %b want 11100",
                {b2.pc_write, b2.IF_ID_write, b2.ID_EX_write, b2.IF_ID_flush, b2.ID_EX_bubble});
        end
        total++;
        if ({b2.fwd_a, b2.fwd_b, b2.stall_cnt, b2.flush_cnt} !== 10'b0) begin
            bad++; $display("FAIL rst_regs: got fwd %b/%b cnt %0d/%0d want all 0",
                b2.fwd_a, b2.fwd_b, b2.stall_cnt, b2.flush_cnt);
        end
        clear_inputs();
        rst_n = 1'b1;
        #1;
        total++;
        if ({b2.pc_write, b2.IF_ID_write, b2.ID_EX_write, b2.IF_ID_flush, b2.ID_EX_bubble} !== 5'b11100) begin
            bad++; $display("FAIL idle_enables: got %b want 11100",
                {b2.pc_write, b2.IF_ID_write, b2.ID_EX_write, b2.IF_ID_flush, b2.ID_EX_bubble});
        end
    endtask

    task automatic test_load_use;
        do_reset();
        ID_EX_regwrite = 1'b1; ID_EX_rd_nz = 1'b1; zero1 = 1'b1; use_rs1 = 1'b1;
        tick();
        total++;
        if (b2.fwd_a !== 2'b01) begin bad++; $display("FAIL lu_pre_fwd: got %b want 01", b2.fwd_a); end
        ID_EX_memread = 1'b1;
        #1;
        total++;
        if ({b2.pc_write, b2.IF_ID_write, b2.ID_EX_write, b2.ID_EX_bubble, b2.IF_ID_flush} !== 5'b00110) begin
            bad++; $display("FAIL lu_comb: got %b want 00110",
                {b2.pc_write, b2.IF_ID_write, b2.ID_EX_write, b2.ID_EX_bubble, b2.IF_ID_flush});
        end
        tick();
        clear_inputs();
        total++;
        if (b2.fwd_a !== 2'b00) begin bad++; $display("FAIL lu_fwd: got %b want 00", b2.fwd_a); end
        total++;
        if (b2.stall_cnt !== 3'd1) begin bad++; $display("FAIL lu_stall_cnt: got %0d want 1", b2.stall_cnt); end
        #1;
        total++;
        if (b2.pc_write !== 1'b1) begin bad++; $display("FAIL lu_release: got %b want 1", b2.pc_write); end
    endtask

    task automatic test_forward;
        do_reset();
        ID_EX_regwrite = 1'b1; ID_EX_rd_nz = 1'b1; EX_MEM_regwrite = 1'b1; EX_MEM_rd_nz = 1'b1;
        zero1 = 1'b1; zero3 = 1'b1; use_rs1 = 1'b1; zero4 = 1'b1; use_rs2 = 1'b1;
        #1;
        total++;
        if ({b2.pc_write, b2.ID_EX_bubble} !== 2'b10) begin
            bad++; $display("FAIL dbl_nostall: got %b want 10", {b2.pc_write, b2.ID_EX_bubble});
        end
        tick();
        total++;
        if ({b2.fwd_a, b2.fwd_b} !== 4'b0110) begin
            bad++; $display("FAIL dbl_fwd: got %b/%b want 01/10", b2.fwd_a, b2.fwd_b);
        end
        ID_EX_regwrite = 1'b0;
        tick();
        total++;
        if (b2.fwd_a !== 2'b10) begin bad++; $display("FAIL m1off_fwd: got %b want 10", b2.fwd_a); end
        ID_EX_regwrite = 1'b1; ID_EX_rd_nz = 1'b0; EX_MEM_rd_nz = 1'b0;
        tick();
        total++;
        if ({b2.fwd_a, b2.fwd_b} !== 4'b0000) begin
            bad++; $display("FAIL x0_fwd: got %b/%b want 00/00", b2.fwd_a, b2.fwd_b);
        end
        total++;
        if (b2.stall_cnt !== 3'd0) begin bad++; $display("FAIL fwd_stall_cnt: got %0d want 0", b2.stall_cnt); end
        clear_inputs();
    endtask

    task automatic test_branch;
        do_reset();
        branch_taken = 1'b1;
        #1;
        total++;
        if ({b2.IF_ID_flush, b2.ID_EX_bubble, b2.pc_write, b2.IF_ID_write, b2.ID_EX_write} !== 5'b11111) begin
            bad++; $display("FAIL br_cycle0: got %b want 11111",
                {b2.IF_ID_flush, b2.ID_EX_bubble, b2.pc_write, b2.IF_ID_write, b2.ID_EX_write});
        end
        tick();
        branch_taken = 1'b0;
        #1;
        total++;
        if (b2.IF_ID_flush !== 1'b1) begin bad++; $display("FAIL br_cycle1: got %b want 1", b2.IF_ID_flush); end
        tick();
        total++;
        if (b2.IF_ID_flush !== 1'b0) begin bad++; $display("FAIL br_cycle2: got %b want 0", b2.IF_ID_flush); end
        total++;
        if (b3.IF_ID_flush !== 1'b1) begin bad++; $display("FAIL br3_cycle2: got %b want 1", b3.IF_ID_flush); end
        total++;
        if (b2.flush_cnt !== 3'd2) begin bad++; $display("FAIL br_flush_cnt: got %0d want 2", b2.flush_cnt); end
    endtask

    task automatic test_branch_and_lu;
        do_reset();
        branch_taken = 1'b1;
        ID_EX_memread = 1'b1; ID_EX_regwrite = 1'b1; ID_EX_rd_nz = 1'b1; zero2 = 1'b1; use_rs2 = 1'b1;
        #1;
        total++;
        if ({b2.IF_ID_flush, b2.pc_write, b2.IF_ID_write} !== 3'b111) begin
            bad++; $display("FAIL brlu_comb: got %b want 111", {b2.IF_ID_flush, b2.pc_write, b2.IF_ID_write});
        end
        tick();
        branch_taken = 1'b0;
        total++;
        if (b2.stall_cnt !== 3'd0) begin bad++; $display("FAIL brlu_stall_cnt: got %0d want 0", b2.stall_cnt); end
        #1;
        total++;
        if ({b2.IF_ID_flush, b2.pc_write} !== 2'b11) begin
            bad++; $display("FAIL brlu_flush1: got %b want 11", {b2.IF_ID_flush, b2.pc_write});
        end
        tick();
        clear_inputs();
    endtask

    task automatic test_freeze;
        do_reset();
        branch_taken = 1'b1;
        tick();
        branch_taken = 1'b0;
        ex_busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++;
            if ({b3.pc_write, b3.IF_ID_write, b3.ID_EX_write, b3.IF_ID_flush, b3.ID_EX_bubble} !== 5'b00000) begin
                bad++; $display("FAIL frz_cycle%0d: got %b want 00000", i,
                    {b3.pc_write, b3.IF_ID_write, b3.ID_EX_write, b3.IF_ID_flush, b3.ID_EX_bubble});
            end
            tick();
        end
        ex_busy = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            total++;
            if ({b3.IF_ID_flush, b3.pc_write} !== 2'b11) begin
                bad++; $display("FAIL frz_resume%0d: got %b want 11", i, {b3.IF_ID_flush, b3.pc_write});
            end
            tick();
        end
        total++;
        if (b3.IF_ID_flush !== 1'b0) begin bad++; $display("FAIL frz_done: got %b want 0", b3.IF_ID_flush); end
        total++;
        if (b3.stall_cnt !== 16'd3) begin bad++; $display("FAIL frz_stall_cnt: got %0d want 3", b3.stall_cnt); end
        total++;
        if (b3.flush_cnt !== 16'd3) begin bad++; $display("FAIL frz_flush_cnt: got %0d want 3", b3.flush_cnt); end
    endtask

    task automatic test_saturate;
        do_reset();
        ex_busy = 1'b1;
        repeat (9) tick();
        ex_busy = 1'b0;
        total++;
        if (b2.stall_cnt !== 3'd7) begin bad++; $display("FAIL sat_stall_cnt: got %0d want 7", b2.stall_cnt); end
        total++;
        if (b3.stall_cnt !== 16'd9) begin bad++; $display("FAIL wide_stall_cnt: got %0d want 9", b3.stall_cnt); end
    endtask

    task automatic test_reset_mid_flush;
        do_reset();
        ex_busy = 1'b1;
        tick();
        ex_busy = 1'b0;
        branch_taken = 1'b1;
        tick();
        branch_taken = 1'b0;
        #1;
        total++;
        if ({b3.IF_ID_flush, b3.stall_cnt, b3.flush_cnt} !== {1'b1, 16'd1, 16'd1}) begin
            bad++; $display("FAIL mid_pre: got flush %b cnt %0d/%0d want 1 1/1",
                b3.IF_ID_flush, b3.stall_cnt, b3.flush_cnt);
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({b3.IF_ID_flush, b3.ID_EX_bubble, b3.pc_write} !== 3'b001) begin
            bad++; $display("FAIL mid_rst_out: got %b want 001", {b3.IF_ID_flush, b3.ID_EX_bubble, b3.pc_write});
        end
        total++;
        if ({b3.stall_cnt, b3.flush_cnt, b3.fwd_a, b3.fwd_b} !== 36'd0) begin
            bad++; $display("FAIL mid_rst_regs: got cnt %0d/%0d fwd %b/%b want 0",
                b3.stall_cnt, b3.flush_cnt, b3.fwd_a, b3.fwd_b);
        end
        tick();
        rst_n = 1'b1;
        #1;
        total++;
        if (b3.IF_ID_flush !== 1'b0) begin bad++; $display("FAIL mid_run0: got %b want 0", b3.IF_ID_flush); end
        tick();
        total++;
        if ({b3.IF_ID_flush, b3.flush_cnt} !== {1'b0, 16'd0}) begin
            bad++; $display("FAIL mid_run1: got flush %b cnt %0d want 0 0", b3.IF_ID_flush, b3.flush_cnt);
        end
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_load_use();
        test_forward();
        test_branch();
        test_branch_and_lu();
        test_freeze();
        test_saturate();
        test_reset_mid_flush();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
